// File: rtl/npc_mem_pkg.sv
// Shared definitions for the npc instruction-memory path: responder state
// encoding, default base address and the address legality rule.
package npc_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } isram_state_t;

   localparam logic [31:0] ISRAM_BASE_DEFAULT = 32'h8000_0000;

   // Legal: word aligned, no borrow from addr-base, word index below depth.
   function automatic logic addr_ok(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned depth);
      logic [31:0] off;
      off = addr - base;
      return (addr >= base) && (addr[1:0] == 2'b00) && ((off >> 2) < depth);
   endfunction

endpackage

// File: rtl/isram_resp_if.sv
// Fetch request/response handshake plus the preload write port.
interface isram_resp_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   modport master (
      output req_valid, req_addr, resp_ready, wr_en, wr_addr, wr_data,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_addr, resp_ready, wr_en, wr_addr, wr_data,
      output req_ready, resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/isram_array.sv
// DEPTH x 32 single-clock memory: one synchronous write port, one registered
// read port that forwards a same-edge write to the word being read.
module isram_array #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic          re_i,
   input  logic          rclr_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);
   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Only the read register is reset; array contents survive reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         if (rclr_i)
            rdata_q <= '0;
         else if (we_i && (waddr_i == raddr_i))
            rdata_q <= wdata_i;
         else
            rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/isram_resp.sv
// Instruction-SRAM responder: one outstanding word fetch, fixed LATENCY from
// accept to response, error flag for misaligned or out-of-window addresses.
module isram_resp
   import npc_mem_pkg::*;
#(
   parameter logic [31:0] BASE    = ISRAM_BASE_DEFAULT,
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input logic         clk,
   input logic         rst,
   isram_resp_if.slave bus
);
   localparam int unsigned AW     = $clog2(DEPTH);
   localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

   function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE;
      return AW'(off >> 2);
   endfunction

   isram_state_t state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [31:0]  addr_q, addr_d;
   logic         err_q, err_d;
   logic         rvalid_q, rvalid_d;
   logic         rerr_q, rerr_d;

   logic         req_err;
   logic         rd_en;
   logic         rd_err;
   logic [31:0]  rd_addr;
   logic         wr_ok;
   logic [31:0]  rdata;

   assign req_err = !addr_ok(bus.req_addr, BASE, DEPTH);
   assign wr_ok   = bus.wr_en && addr_ok(bus.wr_addr, BASE, DEPTH);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      err_d    = err_q;
      rvalid_d = rvalid_q;
      rerr_d   = rerr_q;
      rd_en    = 1'b0;
      rd_addr  = addr_q;
      rd_err   = err_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d = bus.req_addr;
               err_d  = req_err;
               if (LATENCY == 1) begin
                  // Single-cycle latency reads straight from the request.
                  state_d  = RESP;
                  rd_en    = 1'b1;
                  rd_addr  = bus.req_addr;
                  rd_err   = req_err;
                  rvalid_d = 1'b1;
                  rerr_d   = req_err;
               end else begin
                  state_d = WAIT;
                  cnt_d   = LAT_M1;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d  = RESP;
               rd_en    = 1'b1;
               rvalid_d = 1'b1;
               rerr_d   = err_q;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_d  = IDLE;
               rvalid_d = 1'b0;
               rerr_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         err_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         err_q    <= err_d;
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
      end
   end

   isram_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_ok),
      .waddr_i (word_idx(bus.wr_addr)),
      .wdata_i (bus.wr_data),
      .re_i    (rd_en),
      .rclr_i  (rd_err),
      .raddr_i (word_idx(rd_addr)),
      .rdata_o (rdata)
   );

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = rvalid_q;
   assign bus.resp_err   = rerr_q;
   assign bus.resp_data  = rdata;
endmodule
